lcd_bus_driver: RTL
===================

Name: lcd_bus_driver

Overview:
- Downstream physical-bus stage for the 1602 character LCD.
- Consumes 10-bit command/data words {RS, RW, D[7:0]} from the init and write sequencers through a valid/ready handshake.
- Drives the HD44780 pins with correct address-setup, enable-pulse-width, hold and execution-delay timing.
- Replaces free-running divider enables with a single-clock, handshake-paced timing engine.

Parameters:
- T_POWERUP, 2000000, cycles after reset before the first word is accepted (40 ms at 50 MHz)
- T_AS, 4, cycles RS/D are stable before E rises
- T_PW, 23, cycles E is held high
- T_AH, 2, cycles RS/D are held after E falls
- T_CMD, 2000, execution wait for normal commands and characters (40 us)
- T_LONG, 82000, execution wait for clear display and return home (1.64 ms)
- CNT_W, 22, delay counter width; must hold max(T_*)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_word  in  10  [9]=RS, [8]=RW, [7:0]=D
- in_valid  in  1  in_word is valid
- in_ready  out  1  driver can accept a word
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; always 0
- lcd_e  out  1  LCD enable strobe
- lcd_d  out  8  LCD data bus
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values (rst_n low at a clk edge): lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_d=0, in_ready=0, busy=1, state=POWERUP, counter=T_POWERUP-1.
- Reset mid-transfer aborts immediately. E drops to 0 on the same edge, and the power-up wait restarts.
- All outputs are registered.
- FSM states: POWERUP, IDLE, SETUP, E_HIGH, HOLD, WAIT.
- POWERUP: counts down T_POWERUP cycles, then moves to IDLE.
- IDLE: in_ready=1, busy=0. When in_valid && in_ready, the word is latched and the FSM moves to SETUP. lcd_rs and lcd_d update on that edge; lcd_e stays 0.
- SETUP: lasts T_AS cycles, then E_HIGH.
- E_HIGH: lcd_e=1 for exactly T_PW cycles. lcd_e rises on entry and falls on the edge that enters HOLD.
- HOLD: lasts T_AH cycles with the bus unchanged, then WAIT.
- WAIT: lasts T_LONG cycles if the latched RS=0 and D is in {0x01, 0x02, 0x03}; otherwise T_CMD cycles. Then IDLE.
- D=0x00 with RS=0 is a plain command and uses T_CMD.
- Latency from accept edge to in_ready high again = 1 + T_AS + T_PW + T_AH + T_WAIT cycles.
- Maximum throughput is one word per that period. IDLE always lasts at least one cycle, so in_ready pulses high between words.
- lcd_rs and lcd_d keep the last word's values through WAIT and IDLE until the next accept.
- RW bit [8] is ignored; lcd_rw is tied low because the driver is write-only and never polls the busy flag.
- in_valid while not in IDLE is ignored; the upstream holds the word until it sees in_ready.
- in_word changes outside the accept cycle have no effect on the pins.
- Every T_* parameter must be ≥ 1. T_*=1 means a single cycle in that state.
- The counter is a loadable down-counter: it is loaded with T-1 on state entry, and the state exits when it reaches 0.

Decomposition:
- Shared package lcd_pkg holds:
  - word field indices: RS_BIT=9, RW_BIT=8, D_MSB=7
  - command constants: CMD_CLEAR=8'h01, CMD_HOME=8'h02, CMD_SET_DDRAM=8'h80, LINE2_ADDR=8'h40
  - the FSM state enum
- One sub-module, lcd_delay_counter (CNT_W-bit loadable down-counter, inputs load/value, output done). It is reused later by the init sequencer.

Test Plan (overrides: T_POWERUP=10, T_AS=2, T_PW=3, T_AH=1, T_CMD=5, T_LONG=20):
1. Release rst_n with in_valid=1 held → in_ready stays 0 for 10 cycles after reset release, then goes 1; lcd_e stays 0 throughout power-up.
2. Accept 10'b10_0100_0001 ('A' write) at cycle 0:
   - lcd_rs=1 and lcd_d=0x41 from cycle 1
   - lcd_e=1 in cycles 3-5 only
   - bus stable through cycle 6
   - in_ready=1 again at cycle 12
3. Accept command 0x01 (RS=0) → in_ready returns 1 at cycle 27 (1+2+3+1+20); accept 0x03 → also 27; accept 0x00 → 12; accept RS=1 with D=0x01 → 12.
4. Back-to-back words with in_valid held high and in_word = 0x080, 0x241, 0x242 → exactly three E pulses, each carrying the correct RS/D; in_ready high for exactly one cycle between accepts; no word dropped or duplicated.
5. Assert rst_n=0 during E_HIGH → lcd_e=0 on the next edge, all outputs zeroed, and the full 10-cycle power-up is repeated before in_ready=1.
6. Drive in_word=0x3FF (RW=1) → lcd_rw remains 0, lcd_d=0xFF, lcd_rs=1, normal 12-cycle transfer.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared word layout, LCD command constants and driver FSM states.
// Ports: none (package).
package lcd_pkg;

    localparam int RS_BIT = 9;
    localparam int RW_BIT = 8;
    localparam int D_MSB  = 7;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT  = 8'h03;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LINE2_ADDR    = 8'h40;

    typedef enum logic [2:0] {POWERUP, IDLE, SETUP, E_HIGH, HOLD, WAIT} lcd_state_t;

    // Clear display and return home (0x03 decodes as return home) need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return !rs && (d == CMD_CLEAR || d == CMD_HOME || d == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: loadable down-counter that flags done when it reaches zero.
// Ports: clk, rst_n (sync, active-low, reloads RST_VAL), load/value (load value),
//        done (count is zero; counter holds at zero).
module lcd_delay_counter #(
    parameter int              CNT_W   = 22,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;

    assign done = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n)     r_cnt <= RST_VAL;
        else if (load)  r_cnt <= value;
        else if (!done) r_cnt <= r_cnt - 1'b1;
    end

endmodule

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: paces {RS,RW,D} words onto HD44780 pins with setup/enable/hold/exec timing.
// Ports: clk, rst_n (sync, active-low); in_word/in_valid/in_ready upstream handshake;
//        lcd_rs, lcd_rw (tied 0), lcd_e, lcd_d LCD pins; busy high outside IDLE.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 2000000,
    parameter int T_AS      = 4,
    parameter int T_PW      = 23,
    parameter int T_AH      = 2,
    parameter int T_CMD     = 2000,
    parameter int T_LONG    = 82000,
    parameter int CNT_W     = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] in_word,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_d,
    output logic       busy
);

    lcd_state_t       r_state;
    logic             r_rs;
    logic             r_e;
    logic [7:0]       r_d;
    logic             r_ready;
    logic             r_busy;
    logic             w_done;
    logic             w_accept;
    logic             w_load;
    logic [CNT_W-1:0] w_value;
    logic             w_unused_rw;

    // The driver never reads, so RW is dropped.
    assign w_unused_rw = in_word[RW_BIT];

    assign w_accept = (r_state == IDLE) && r_ready && in_valid;

    // Load the next state's duration on every timed-state transition.
    always_comb begin
        w_load  = w_accept || (w_done && (r_state == SETUP || r_state == E_HIGH || r_state == HOLD));
        w_value = w_accept               ? CNT_W'(T_AS - 1)   :
                  (r_state == SETUP)     ? CNT_W'(T_PW - 1)   :
                  (r_state == E_HIGH)    ? CNT_W'(T_AH - 1)   :
                  is_long_cmd(r_rs, r_d) ? CNT_W'(T_LONG - 1) : CNT_W'(T_CMD - 1);
    end

    lcd_delay_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(T_POWERUP - 1))
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .value (w_value),
        .done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= POWERUP;
            r_rs    <= 1'b0;
            r_d     <= 8'h00;
            r_e     <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                POWERUP: if (w_done) begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                IDLE: if (w_accept) begin
                    r_state <= SETUP;
                    r_rs    <= in_word[RS_BIT];
                    r_d     <= in_word[D_MSB:0];
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                end
                SETUP: if (w_done) begin
                    r_state <= E_HIGH;
                    r_e     <= 1'b1;
                end
                E_HIGH: if (w_done) begin
                    r_state <= HOLD;
                    r_e     <= 1'b0;
                end
                HOLD: if (w_done) r_state <= WAIT;
                WAIT: if (w_done) begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: r_state <= POWERUP;
            endcase
        end
    end

    assign in_ready = r_ready;
    assign lcd_rs   = r_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = r_e;
    assign lcd_d    = r_d;
    assign busy     = r_busy;

endmodule
